ddr2_cmd_scheduler: RTL

//  Sits between the per-bank controllers and the DFI control bus. Each cycle it picks
//  at most one ACT/RD/WR/PRE/REF request from NUM_BANKS bank-scheduler ports and

---
 rtl/ddr2_cmd_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ddr2_cmd_scheduler.sv
// DDR2 inter-bank command scheduler.
// Each cycle it picks at most one ACT/RD/WR/PRE/REF request from the bank
// controllers and issues it as a registered command on the DFI control bus.
// Grants are combinational in the selection cycle. The command appears on DFI
// one cycle later. Inter-bank spacing (tRRD, tCCD, tWTR, tRTW) is enforced here.
module ddr2_cmd_scheduler #(
  parameter int  NUM_BANKS  = 8,
  parameter int  RA_WIDTH   = 14,
  parameter int  CA_WIDTH   = 10,
  parameter int  ADDR_WIDTH = 14,
  parameter int  TW         = 4,
  localparam int BA_WIDTH   = $clog2(NUM_BANKS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          init_done,
  input  logic [TW-1:0]                 t_rrd,
  input  logic [TW-1:0]                 t_ccd,
  input  logic [TW-1:0]                 t_wtr,
  input  logic [TW-1:0]                 t_rtw,
  input  logic [NUM_BANKS-1:0]          act_req,
  input  logic [NUM_BANKS-1:0]          rd_req,
  input  logic [NUM_BANKS-1:0]          wr_req,
  input  logic [NUM_BANKS-1:0]          pre_req,
  input  logic [NUM_BANKS-1:0]          ref_req,
  input  logic [NUM_BANKS*RA_WIDTH-1:0] ra,
  input  logic [NUM_BANKS*CA_WIDTH-1:0] ca,
  output logic [NUM_BANKS-1:0]          act_gnt,
  output logic [NUM_BANKS-1:0]          rd_gnt,
  output logic [NUM_BANKS-1:0]          wr_gnt,
  output logic [NUM_BANKS-1:0]          pre_gnt,
  output logic [NUM_BANKS-1:0]          ref_gnt,
  output logic                          dfi_cke,
  output logic                          dfi_cs_n,
  output logic                          dfi_ras_n,
  output logic                          dfi_cas_n,
  output logic                          dfi_we_n,
  output logic [BA_WIDTH-1:0]           dfi_ba,
  output logic [ADDR_WIDTH-1:0]         dfi_addr,
  output logic                          dfi_odt
);

  typedef enum logic [2:0] {CMD_NONE, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF} cmd_e;
  typedef enum logic [1:0] {CAS_NONE, CAS_RD, CAS_WR} cas_e;

  logic [TW-1:0]       rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
  logic [BA_WIDTH-1:0] rr_ptr;
  cas_e                last_cas;

  cmd_e                sel_cmd;
  logic [BA_WIDTH-1:0] sel_bank;
  logic [NUM_BANKS-1:0] sel_onehot;
  logic                rd_ok, wr_ok, act_ok;
  logic [BA_WIDTH:0]   act_pick, rd_pick, wr_pick, pre_pick;

  // Round-robin search from ptr; returns {found, index}.
  function automatic logic [BA_WIDTH:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                                input logic [BA_WIDTH-1:0]  ptr);
    logic [BA_WIDTH-1:0] idx;
    rr_pick = '0;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      idx = BA_WIDTH'((int'(ptr) + i) % NUM_BANKS);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // Down-counter step: load t-1 on issue (0 or 1 both mean no wait), else saturate at 0.
  function automatic logic [TW-1:0] cnt_next(input logic [TW-1:0] cnt,
                                             input logic          load,
                                             input logic [TW-1:0] t);
    if (load) return (t == '0) ? '0 : t - 1'b1;
    return (cnt == '0) ? '0 : cnt - 1'b1;
  endfunction

  assign act_ok = (rrd_cnt == '0);
  assign rd_ok  = (ccd_cnt == '0) && (wtr_cnt == '0);
  assign wr_ok  = (ccd_cnt == '0) && (rtw_cnt == '0);

  assign act_pick = rr_pick(act_req & {NUM_BANKS{act_ok}}, rr_ptr);
  assign rd_pick  = rr_pick(rd_req  & {NUM_BANKS{rd_ok}},  rr_ptr);
  assign wr_pick  = rr_pick(wr_req  & {NUM_BANKS{wr_ok}},  rr_ptr);
  assign pre_pick = rr_pick(pre_req, rr_ptr);

  // Class arbitration: REF > RD/WR (last CAS direction breaks ties) > ACT > PRE.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    sel_cmd  = CMD_NONE;
    sel_bank = '0;
    if (rst_n && init_done) begin
      if (&ref_req) begin
        sel_cmd = CMD_REF;
      end else if (rd_pick[BA_WIDTH] && (!wr_pick[BA_WIDTH] || last_cas != CAS_WR)) begin
        sel_cmd  = CMD_RD;
        sel_bank = rd_pick[BA_WIDTH-1:0];
      end else if (wr_pick[BA_WIDTH]) begin
        sel_cmd  = CMD_WR;
        sel_bank = wr_pick[BA_WIDTH-1:0];
      end else if (act_pick[BA_WIDTH]) begin
        sel_cmd  = CMD_ACT;
        sel_bank = act_pick[BA_WIDTH-1:0];
      end else if (pre_pick[BA_WIDTH]) begin
        sel_cmd  = CMD_PRE;
        sel_bank = pre_pick[BA_WIDTH-1:0];
      end
    end
  end

  // Decode the selection into one-cycle grant pulses.
  always_comb begin
    sel_onehot = NUM_BANKS'(1) << sel_bank;
    act_gnt    = (sel_cmd == CMD_ACT) ? sel_onehot : '0;
    rd_gnt     = (sel_cmd == CMD_RD)  ? sel_onehot : '0;
    wr_gnt     = (sel_cmd == CMD_WR)  ? sel_onehot : '0;
    pre_gnt    = (sel_cmd == CMD_PRE) ? sel_onehot : '0;
    ref_gnt    = (sel_cmd == CMD_REF) ? '1 : '0;
  end

  // Register the selected command onto the DFI control bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dfi_cke                                    <= 1'b0;
      {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} <= 4'b1111;
      dfi_ba                                     <= '0;
      dfi_addr                                   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      dfi_cke <= init_done;
      dfi_ba  <= sel_bank;
      // Column widths stay below A10, so zero-extension keeps auto-precharge off.
      case (sel_cmd)
        CMD_ACT: begin
          {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} <= 4'b0011;
          dfi_addr <= ADDR_WIDTH'(ra[sel_bank*RA_WIDTH +: RA_WIDTH]);
        end
        CMD_RD: begin
          {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} <= 4'b0101;
          dfi_addr <= ADDR_WIDTH'(ca[sel_bank*CA_WIDTH +: CA_WIDTH]);
        end
        CMD_WR: begin
          {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} <= 4'b0100;
          dfi_addr <= ADDR_WIDTH'(ca[sel_bank*CA_WIDTH +: CA_WIDTH]);
        end
        CMD_PRE: begin
          {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} <= 4'b0010;
          dfi_addr <= '0;
        end
        CMD_REF: begin
          {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} <= 4'b0001;
          dfi_addr <= '0;
        end
        default: begin
          {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} <= 4'b1111;
          dfi_addr <= '0;
        end
      endcase
    end
  end

  // Timing counters, round-robin pointer and last CAS direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd_cnt  <= '0;
      ccd_cnt  <= '0;
      wtr_cnt  <= '0;
      rtw_cnt  <= '0;
      rr_ptr   <= '0;
      last_cas <= CAS_NONE;
    end else begin
      rrd_cnt <= cnt_next(rrd_cnt, sel_cmd == CMD_ACT, t_rrd);
      ccd_cnt <= cnt_next(ccd_cnt, sel_cmd == CMD_RD || sel_cmd == CMD_WR, t_ccd);
      wtr_cnt <= cnt_next(wtr_cnt, sel_cmd == CMD_WR, t_wtr);
      rtw_cnt <= cnt_next(rtw_cnt, sel_cmd == CMD_RD, t_rtw);
      if (sel_cmd == CMD_RD) last_cas <= CAS_RD;
      if (sel_cmd == CMD_WR) last_cas <= CAS_WR;
      // All-bank refresh does not move the fairness pointer.
      if (sel_cmd != CMD_NONE && sel_cmd != CMD_REF)
        rr_ptr <= (sel_bank == BA_WIDTH'(NUM_BANKS - 1)) ? '0 : sel_bank + 1'b1;
    end
  end

  assign dfi_odt = 1'b0;

endmodule
